// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS
// pipeline. Owns the fetch PC, captures the fetched word into IF/ID, and
// computes the branch and jump targets from the IF/ID contents.
//
// Ports
//   clock        in   pipeline clock, rising edge
//   reset        in   synchronous, active-high reset
//   stall_f      in   hold the PC
//   stall_d      in   hold the IF/ID register
//   pcsrc_d      in   taken branch resolved in decode
//   jump_d       in   jump in decode
//   imem_addr    out  instruction memory byte address (equals pc_f)
//   imem_rdata   in   instruction word, combinational read of imem_addr
//   pc_f         out  current fetch PC
//   instr_d      out  IF/ID instruction
//   pc_plus4_d   out  IF/ID PC+4
//   valid_d      out  IF/ID holds a real fetched instruction (0 = bubble)
//   opcode_d, rs_d, rt_d, rd_d, funct_d   decoded fields of instr_d
//   signimm_d    out  sign-extended instr_d[15:0]
//   pc_branch_d  out  pc_plus4_d + (signimm_d << 2)
//   pc_jump_d    out  {pc_plus4_d[31:28], instr_d[25:0], 2'b00}
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        pcsrc_d,
  input  logic        jump_d,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [5:0]  opcode_d,
  output logic [4:0]  rs_d,
  output logic [4:0]  rt_d,
  output logic [4:0]  rd_d,
  output logic [5:0]  funct_d,
  output logic [31:0] signimm_d,
  output logic [31:0] pc_branch_d,
  output logic [31:0] pc_jump_d
);

  logic [31:0] pc_q,       pc_d;
  logic [31:0] instr_q,    instr_d_n;
  logic [31:0] pc_plus4_q, pc_plus4_d_n;
  logic        valid_q,    valid_d_n;
  logic [31:0] pc_plus4_f_s;
  logic [31:0] signimm_s;
  logic [31:0] pc_branch_s;
  logic [31:0] pc_jump_s;

  // Targets are derived from the instruction currently sitting in IF/ID.
  assign pc_plus4_f_s = pc_q + 32'd4;
  assign signimm_s    = {{16{instr_q[15]}}, instr_q[15:0]};
  assign pc_branch_s  = pc_plus4_q + {signimm_s[29:0], 2'b00};
  assign pc_jump_s    = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};

  // Next-PC selection: stall holds (redirects ignored), jump beats branch.
  always_comb begin
    pc_d = pc_plus4_f_s;
    if (stall_f) begin
      pc_d = pc_q;
    end else if (jump_d) begin
      pc_d = pc_jump_s;
    end else if (pcsrc_d) begin
      pc_d = pc_branch_s;
    end else begin
      pc_d = pc_plus4_f_s;
    end
  end

  // IF/ID next state: stall beats flush; a redirect squashes the wrong-path word.
  always_comb begin
    instr_d_n    = imem_rdata;
    pc_plus4_d_n = pc_plus4_f_s;
    valid_d_n    = 1'b1;
    if (stall_d) begin
      instr_d_n    = instr_q;
      pc_plus4_d_n = pc_plus4_q;
      valid_d_n    = valid_q;
    end else if (jump_d || pcsrc_d) begin
      instr_d_n    = NOP_INSTR;
      pc_plus4_d_n = 32'h0000_0000;
      valid_d_n    = 1'b0;
    end else begin
      instr_d_n    = imem_rdata;
      pc_plus4_d_n = pc_plus4_f_s;
      valid_d_n    = 1'b1;
    end
  end

  // PC and IF/ID registers with synchronous reset overriding all controls.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d_n;
      pc_plus4_q <= pc_plus4_d_n;
      valid_q    <= valid_d_n;
    end
  end

  assign imem_addr   = pc_q;
  assign pc_f        = pc_q;
  assign instr_d     = instr_q;
  assign pc_plus4_d  = pc_plus4_q;
  assign valid_d     = valid_q;
  assign opcode_d    = instr_q[31:26];
  assign rs_d        = instr_q[25:21];
  assign rt_d        = instr_q[20:16];
  assign rd_d        = instr_q[15:11];
  assign funct_d     = instr_q[5:0];
  assign signimm_d   = signimm_s;
  assign pc_branch_d = pc_branch_s;
  assign pc_jump_d   = pc_jump_s;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Scoreboard bench for fetch_stage. Two instances: dut_a (RESET_PC = 0) takes
// directed then random control stimulus; dut_b (RESET_PC = FFFF_FFF8) runs
// free with only the shared reset, exercising PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } st_t;

  typedef struct packed {
    st_t a;
    st_t b;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        stall_f, stall_d, pcsrc_d, jump_d;
  logic [31:0] imem_rdata_a, imem_rdata_b;

  logic [31:0] imem_addr_a, pc_f_a, instr_d_a, pc_plus4_d_a, signimm_d_a;
  logic [31:0] pc_branch_d_a, pc_jump_d_a;
  logic        valid_d_a;
  logic [5:0]  opcode_d_a, funct_d_a;
  logic [4:0]  rs_d_a, rt_d_a, rd_d_a;

  logic [31:0] imem_addr_b, pc_f_b, instr_d_b, pc_plus4_d_b, signimm_d_b;
  logic [31:0] pc_branch_d_b, pc_jump_d_b;
  logic        valid_d_b;
  logic [5:0]  opcode_d_b, funct_d_b;
  logic [4:0]  rs_d_b, rt_d_b, rd_d_b;

  int unsigned n_vec;
  int unsigned n_miss;
  exp_t        sb_q[$];
  st_t         ma, mb;
  logic [31:0] ovr[logic [31:0]];
  bit          hash_mode;

  fetch_stage dut_a (
    .clock(clock), .reset(reset), .stall_f(stall_f), .stall_d(stall_d),
    .pcsrc_d(pcsrc_d), .jump_d(jump_d), .imem_addr(imem_addr_a),
    .imem_rdata(imem_rdata_a), .pc_f(pc_f_a), .instr_d(instr_d_a),
    .pc_plus4_d(pc_plus4_d_a), .valid_d(valid_d_a), .opcode_d(opcode_d_a),
    .rs_d(rs_d_a), .rt_d(rt_d_a), .rd_d(rd_d_a), .funct_d(funct_d_a),
    .signimm_d(signimm_d_a), .pc_branch_d(pc_branch_d_a), .pc_jump_d(pc_jump_d_a)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0000)) dut_b (
    .clock(clock), .reset(reset), .stall_f(1'b0), .stall_d(1'b0),
    .pcsrc_d(1'b0), .jump_d(1'b0), .imem_addr(imem_addr_b),
    .imem_rdata(imem_rdata_b), .pc_f(pc_f_b), .instr_d(instr_d_b),
    .pc_plus4_d(pc_plus4_d_b), .valid_d(valid_d_b), .opcode_d(opcode_d_b),
    .rs_d(rs_d_b), .rt_d(rt_d_b), .rd_d(rd_d_b), .funct_d(funct_d_b),
    .signimm_d(signimm_d_b), .pc_branch_d(pc_branch_d_b), .pc_jump_d(pc_jump_d_b)
  );

  // Clock generator.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory contents: overrides first, then a simple or hashed pattern.
  function automatic logic [31:0] mem_fn(input logic [31:0] addr);
    if (ovr.exists(addr)) return ovr[addr];
    if (!hash_mode) return addr + 32'h0000_0100;
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: one clock of the fetch-stage rules.
  function automatic st_t step(input st_t s, input logic r, input logic sf,
                               input logic sd, input logic br, input logic jp,
                               input logic [31:0] rdata, input logic [31:0] rpc);
    st_t n;
    int signed off;
    logic [31:0] jt, bt;
    n   = s;
    off = int'(signed'(s.instr[15:0]));
    bt  = s.pc4 + 32'(off * 4);
    jt  = {s.pc4[31:28], s.instr[25:0], 2'b00};
    if (r) begin
      n.pc = rpc; n.instr = 32'h0; n.pc4 = 32'h0; n.valid = 1'b0;
      return n;
    end
    if (!sf) n.pc = jp ? jt : (br ? bt : s.pc + 32'd4);
    if (!sd) begin
      if (jp || br) begin
        n.instr = 32'h0; n.pc4 = 32'h0; n.valid = 1'b0;
      end else begin
        n.instr = rdata; n.pc4 = s.pc + 32'd4; n.valid = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector, update the model, push the expectation, then advance.
  task automatic apply(input logic r, input logic sf, input logic sd,
                       input logic br, input logic jp);
    exp_t e;
    reset = r; stall_f = sf; stall_d = sd; pcsrc_d = br; jump_d = jp;
    imem_rdata_a = mem_fn(imem_addr_a);
    imem_rdata_b = mem_fn(imem_addr_b);
    e.a = step(ma, r, sf, sd, br, jp, mem_fn(ma.pc), 32'h0000_0000);
    e.b = step(mb, r, 1'b0, 1'b0, 1'b0, 1'b0, mem_fn(mb.pc), 32'hFFFF_FFF8);
    ma = e.a;
    mb = e.b;
    sb_q.push_back(e);
    @(negedge clock);
  endtask

  // The hazard unit must never stall fetch while letting decode advance.
  always @(posedge clock) begin
    assert (!(stall_f === 1'b1 && stall_d === 1'b0))
      else $error("FAIL illegal stall_f without stall_d");
  end

  // Monitor: after every active edge, compare both instances to the scoreboard.
  always begin
    exp_t e;
    int signed off;
    @(posedge clock);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      off = int'(signed'(e.a.instr[15:0]));
      chk("pc_f",        pc_f_a,        e.a.pc);
      chk("imem_addr",   imem_addr_a,   e.a.pc);
      chk("instr_d",     instr_d_a,     e.a.instr);
      chk("pc_plus4_d",  pc_plus4_d_a,  e.a.pc4);
      chk("valid_d",     {31'h0, valid_d_a}, {31'h0, e.a.valid});
      chk("opcode_d",    {26'h0, opcode_d_a}, {26'h0, e.a.instr[31:26]});
      chk("rs_d",        {27'h0, rs_d_a}, {27'h0, e.a.instr[25:21]});
      chk("rt_d",        {27'h0, rt_d_a}, {27'h0, e.a.instr[20:16]});
      chk("rd_d",        {27'h0, rd_d_a}, {27'h0, e.a.instr[15:11]});
      chk("funct_d",     {26'h0, funct_d_a}, {26'h0, e.a.instr[5:0]});
      chk("signimm_d",   signimm_d_a,   32'(off));
      chk("pc_branch_d", pc_branch_d_a, e.a.pc4 + 32'(off * 4));
      chk("pc_jump_d",   pc_jump_d_a,   {e.a.pc4[31:28], e.a.instr[25:0], 2'b00});
      chk("b_pc_f",      pc_f_b,        e.b.pc);
      chk("b_instr_d",   instr_d_b,     e.b.instr);
      chk("b_valid_d",   {31'h0, valid_d_b}, {31'h0, e.b.valid});
    end
  end

  // Directed vectors: {reset, stall_f, stall_d, pcsrc_d, jump_d}.
  logic [4:0] dir_v [22];

  initial begin
    n_vec = 0; n_miss = 0; hash_mode = 1'b0;
    ma = '0; mb = '0;
    imem_rdata_a = 32'h0; imem_rdata_b = 32'h0;
    ovr[32'h0000_000C] = 32'h1000_FFFE;   // beq, offset -2
    ovr[32'h1000_0004] = 32'h0800_0040;   // j, target 0x100 in upper region
    foreach (dir_v[i]) dir_v[i] = 5'b00000;
    dir_v[0]  = 5'b10000;
    dir_v[5]  = 5'b00010;
    dir_v[8]  = 5'b00001;
    dir_v[15] = 5'b00011;
    dir_v[17] = 5'b01110;
    dir_v[18] = 5'b01110;
    dir_v[19] = 5'b01110;
    dir_v[21] = 5'b10001;

    for (int i = 0; i < 22; i++) begin
      apply(dir_v[i][4], dir_v[i][3], dir_v[i][2], dir_v[i][1], dir_v[i][0]);
      case (i)
        0:  begin chk("rst_pc", pc_f_a, 32'h0); chk("rst_valid", {31'h0, valid_d_a}, 32'h0);
                  chk("b_rst_pc", pc_f_b, 32'hFFFF_FFF8); end
        1:  begin chk("c1_pc", pc_f_a, 32'h4); chk("c1_valid", {31'h0, valid_d_a}, 32'h1);
                  chk("c1_instr", instr_d_a, 32'h100); chk("b_pc1", pc_f_b, 32'hFFFF_FFFC); end
        2:  begin chk("c2_instr", instr_d_a, 32'h104); chk("b_pc_wrap", pc_f_b, 32'h0); end
        4:  begin chk("beq_pc4", pc_plus4_d_a, 32'h10); chk("beq_target", pc_branch_d_a, 32'h8); end
        5:  begin
              chk("beq_pc", pc_f_a, 32'h8);
              chk("beq_flush", {31'h0, valid_d_a}, 32'h0);
              ovr[32'h0000_000C] = 32'h0BFF_FFFC;  // j to 0x0FFF_FFF0
            end
        8:  chk("j1_pc", pc_f_a, 32'h0FFF_FFF0);
        14: chk("j2_pc4", pc_plus4_d_a, 32'h1000_0008);
        15: begin chk("jwins_pc", pc_f_a, 32'h1000_0100); chk("jwins_flush", instr_d_a, 32'h0); end
        19: begin chk("stall_pc", pc_f_a, 32'h1000_0104); chk("stall_instr", instr_d_a, 32'h1000_0200); end
        20: chk("resume_pc", pc_f_a, 32'h1000_0108);
        21: begin chk("rstj_pc", pc_f_a, 32'h0); chk("rstj_valid", {31'h0, valid_d_a}, 32'h0);
                  chk("rstj_instr", instr_d_a, 32'h0); end
        default: ;
      endcase
    end

    ovr.delete();
    hash_mode = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      logic r, s, br, jp;
      r  = ($urandom_range(63) == 0);
      s  = ($urandom_range(7) == 0);
      br = ($urandom_range(5) == 0);
      jp = ($urandom_range(7) == 0);
      apply(r, s, s, br, jp);
    end

    @(posedge clock);
    #2;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline; sits directly upstream of decode and feeds decode, control and hazard logic.
- Owns the PC and computes the branch and jump targets from IF/ID contents.
- Applies the hazard unit's stall_f, stall_d and redirect (pcsrc_d, jump_d) controls.
- Presents decoded instruction fields to the register file, control unit and hazard unit.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall_f  in  1  hold PC.
- stall_d  in  1  hold IF/ID register.
- pcsrc_d  in  1  taken branch resolved in decode.
- jump_d  in  1  jump in decode.
- imem_addr  out  32  instruction memory byte address; equals pc_f.
- imem_rdata  in  32  instruction word, combinational read of imem_addr.
- pc_f  out  32  current fetch PC.
- instr_d  out  32  IF/ID instruction.
- pc_plus4_d  out  32  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real fetched instruction (0 = bubble).
- opcode_d  out  6  instr_d[31:26].
- rs_d  out  5  instr_d[25:21].
- rt_d  out  5  instr_d[20:16].
- rd_d  out  5  instr_d[15:11].
- funct_d  out  6  instr_d[5:0].
- signimm_d  out  32  sign-extended instr_d[15:0].
- pc_branch_d  out  32  pc_plus4_d + (signimm_d << 2).
- pc_jump_d  out  32  {pc_plus4_d[31:28], instr_d[25:0], 2'b00}.

Behaviour:
- One clock (clock); reset is synchronous and active-high. Every state change happens on the rising edge of clock.
- Reset (overrides everything, including mid-stall or mid-redirect):
  - pc_f <= RESET_PC.
  - instr_d <= NOP_INSTR, pc_plus4_d <= 0, valid_d <= 0.
  - Derived outputs follow from these values.
- PC register, next-PC priority:
  1. reset.
  2. stall_f=1: hold pc_f. Redirects are ignored, because the hazard unit only stalls while branch operands are unresolved.
  3. jump_d=1: pc_jump_d.
  4. pcsrc_d=1: pc_branch_d.
  5. Otherwise: pc_f + 4.
- Jump wins when jump_d and pcsrc_d are both asserted.
- All PC arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0, and a negative offset below 0 wraps. No alignment check; bits [1:0] pass through unchanged.
- IF/ID register, priority:
  1. reset.
  2. stall_d=1: hold all IF/ID fields. Stall wins over flush.
  3. Flush when (jump_d | pcsrc_d): load NOP_INSTR, pc_plus4_d <= 0, valid_d <= 0. This squashes the wrong-path instruction fetched behind the branch or jump.
  4. Otherwise: instr_d <= imem_rdata, pc_plus4_d <= pc_f + 4, valid_d <= 1.
- Latency: the word at address pc_f appears on instr_d one cycle later. A taken redirect gives exactly one bubble.
- Field outputs, signimm_d, pc_branch_d and pc_jump_d are combinational from the IF/ID register, with no extra latency.
- imem_addr = pc_f combinationally.
- Combined case stall_f=1, stall_d=0: this is illegal from the hazard unit. If it occurs, the block still follows the priorities above and duplicates the instruction in IF/ID. The bench flags this case with an assertion but does not require particular behaviour.

Test Plan:
- Reset then 4 free-running cycles, imem returning addr+32'h100 -> imem_addr 0,4,8,C; instr_d 0x100,0x104,0x108 from cycle 2; valid_d 0 in cycle 1, then 1.
- instr_d=0x1000_FFFE (beq, offset -2) at pc_plus4_d=0x10, pcsrc_d pulsed -> pc_f next = 0x08; instr_d=NOP_INSTR, valid_d=0 for one cycle; pc_branch_d=0x08.
- instr_d=0x0800_0040 (j) at pc_plus4_d=0x1000_0008, jump_d and pcsrc_d both high -> pc_f next = 0x1000_0100 (jump wins); IF/ID flushed.
- stall_f=stall_d=1 for 3 cycles with pcsrc_d=1 -> pc_f and instr_d unchanged throughout; after release, normal sequencing resumes from the held PC.
- RESET_PC=32'hFFFF_FFF8, run 3 cycles -> pc_f FFFF_FFF8, FFFF_FFFC, 0000_0000.
- reset asserted during a jump redirect -> next cycle pc_f=RESET_PC, valid_d=0, instr_d=NOP_INSTR.
